seven_segment_scan_alu: RTL

Parametrised successor to the single-digit seven-segment adder display. It captures two WIDTH-bit operands on a load strobe and computes their sum or difference with a carry/borrow flag. It drives a DIGITS-digit multiplexed seven-segment display, one digit at a time, from a free-running scan counter. It sits between the operand registers (switches or bus) and the board display pins.

---
 rtl/seg_pkg.sv | 23 ++
 rtl/hex_to_seg.sv | 11 +
 rtl/seven_segment_scan_alu.sv | 106 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: bit order, hex glyph table and blank pattern.
// Segments are active-high with bit0 = a through bit6 = g.
package seg_pkg;

  typedef enum logic [2:0] {
    SEG_A = 3'd0,
    SEG_B = 3'd1,
    SEG_C = 3'd2,
    SEG_D = 3'd3,
    SEG_E = 3'd4,
    SEG_F = 3'd5,
    SEG_G = 3'd6
  } seg_bit_e;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Entry n holds the glyph for hex digit n (index 15 is listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to seven-segment glyph decoder.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/seven_segment_scan_alu.sv
// Add/subtract unit with a registered result shown on a multiplexed
// DIGITS-digit seven-segment display driven by a free-running scan.
module seven_segment_scan_alu
  import seg_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int REFRESH_DIV = 4,
  parameter bit BLANK_LZ    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               op,
  input  logic               load,
  output logic [6:0]         seg,
  output logic [WIDTH/4-1:0] an,
  output logic               over,
  output logic               frame
);

  localparam int DIGITS = WIDTH / 4;
  localparam int DIV_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [WIDTH:0]    alu;
  logic [WIDTH-1:0]  res_q, res_d;
  logic              over_q, over_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  dig_q, dig_d;
  logic              div_wrap, dig_last;
  logic              frame_q, frame_d;
  logic [6:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        nibble;
  logic [6:0]        dec_seg;
  logic              blank;

  // The extra top bit is the carry for add and the borrow for subtract.
  always_comb begin
    alu    = op ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    res_d  = res_q;
    over_d = over_q;
    if (load) begin
      res_d  = alu[WIDTH-1:0];
      over_d = alu[WIDTH];
    end
  end

  always_comb begin
    div_wrap = (div_q == DIV_W'(REFRESH_DIV - 1));
    dig_last = (dig_q == IDX_W'(DIGITS - 1));
    div_d    = div_wrap ? '0 : div_q + DIV_W'(1);
    dig_d    = dig_q;
    if (div_wrap) begin
      dig_d = dig_last ? '0 : dig_q + IDX_W'(1);
    end
    frame_d = div_wrap && dig_last;
  end

  // Display follows the post-update digit index and result of this edge.
  always_comb begin
    nibble = '0;
    blank  = 1'b0;
    an_d   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (dig_d == IDX_W'(i)) begin
        nibble  = res_d[4*i +: 4];
        an_d[i] = 1'b1;
        blank   = BLANK_LZ && (i > 0) && ((res_d >> (4*i)) == '0);
      end
    end
    seg_d = blank ? SEG_BLANK : dec_seg;
  end

  hex_to_seg u_dec (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_q   <= '0;
      over_q  <= 1'b0;
      div_q   <= '0;
      dig_q   <= '0;
      frame_q <= 1'b0;
      seg_q   <= '0;
      an_q    <= '0;
    end else begin
      res_q   <= res_d;
      over_q  <= over_d;
      div_q   <= div_d;
      dig_q   <= dig_d;
      frame_q <= frame_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign over  = over_q;
  assign frame = frame_q;

endmodule
